// File: rtl/rs232_avm_slave_pkg.sv
// Shared definitions for the RS-232 Avalon-MM slave and its bus master wrapper:
// register offsets, status bit positions and the bus handshake state type.
package rs232_avm_slave_pkg;

  localparam int unsigned RX_OFFSET     = 0;
  localparam int unsigned TX_OFFSET     = 4;
  localparam int unsigned STATUS_OFFSET = 8;

  localparam int unsigned RX_OK_BIT     = 7;
  localparam int unsigned TX_OK_BIT     = 6;
  localparam int unsigned TX_DROP_BIT   = 5;
  localparam int unsigned RX_COUNT_LSB  = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } bus_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with power-of-two depth. A pop on a full FIFO frees the slot for a
// push in the same cycle; a pop on an empty FIFO is ignored.
module uart_byte_fifo #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [7:0]    data_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o,
  output logic [7:0]    head_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          pop_en;
  logic          push_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];
  assign pop_en  = pop_i && !empty_o;
  assign push_en = push_i && (!full_o || pop_en);

  // Storage array; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk_i) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally modulo DEPTH; count tracks occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_en) - CW'(pop_en);
    end
  end

endmodule

// File: rtl/rs232_avm_slave.sv
// Avalon-MM slave exposing an RX byte FIFO, a TX byte FIFO and a status
// register. Every access is accepted exactly one cycle after it is sampled.
module rs232_avm_slave
  import rs232_avm_slave_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned RX_BASE     = RX_OFFSET,
  parameter int unsigned TX_BASE     = TX_OFFSET,
  parameter int unsigned STATUS_BASE = STATUS_OFFSET
) (
  input  logic        avm_clk,
  input  logic        avm_rst,
  input  logic [4:0]  avm_address,
  input  logic        avm_read,
  output logic [31:0] avm_readdata,
  input  logic        avm_write,
  input  logic [31:0] avm_writedata,
  output logic        avm_waitrequest,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready
);

  localparam int unsigned CW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [4:0]  RX_ADDR     = 5'(RX_BASE);
  localparam logic [4:0]  TX_ADDR     = 5'(TX_BASE);
  localparam logic [4:0]  STATUS_ADDR = 5'(STATUS_BASE);

  bus_state_e    state_q, state_d;
  logic [4:0]    addr_q, addr_d;
  logic          rd_op_q, rd_op_d;
  logic          tx_drop_q, tx_drop_d;

  logic          rx_full, rx_empty, tx_full, tx_empty;
  logic [CW-1:0] rx_count, unused_tx_count;
  logic [7:0]    rx_head;
  logic          in_resp, rd_resp, wr_resp;
  logic          rx_pop, rx_push, tx_pop, tx_wr, tx_push_ok, status_clr;
  logic          unused_wdata;

  assign unused_wdata = ^avm_writedata[31:8];

  assign in_resp    = (state_q == S_RESP);
  assign rd_resp    = in_resp && rd_op_q;
  assign wr_resp    = in_resp && !rd_op_q;
  assign rx_pop     = rd_resp && (addr_q == RX_ADDR) && !rx_empty;
  assign status_clr = rd_resp && (addr_q == STATUS_ADDR);
  assign tx_wr      = wr_resp && (addr_q == TX_ADDR);
  assign tx_pop     = !tx_empty && i_tx_ready;
  assign tx_push_ok = !tx_full || tx_pop;

  // A bus pop on a full RX FIFO opens the slot for a serial push that cycle.
  assign o_rx_ready = !rx_full || rx_pop;
  assign rx_push    = i_rx_valid && o_rx_ready;
  assign o_tx_valid = !tx_empty;

  assign avm_waitrequest = !in_resp;

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (avm_clk),
    .rst_ni  (avm_rst),
    .push_i  (rx_push),
    .data_i  (i_rx_data),
    .pop_i   (rx_pop),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count),
    .head_o  (rx_head)
  );

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (avm_clk),
    .rst_ni  (avm_rst),
    .push_i  (tx_wr),
    .data_i  (avm_writedata[7:0]),
    .pop_i   (tx_pop),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (unused_tx_count),
    .head_o  (o_tx_data)
  );

  // Bus handshake: sample a request in idle, answer it in the following cycle.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rd_op_d = rd_op_q;
    unique case (state_q)
      S_IDLE: begin
        if (avm_read || avm_write) begin
          state_d = S_RESP;
          addr_d  = avm_address;
          rd_op_d = avm_read;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sticky drop flag: set by a TX write that finds no room, cleared by a status read.
  always_comb begin
    tx_drop_d = tx_drop_q;
    if (tx_wr && !tx_push_ok) begin
      tx_drop_d = 1'b1;
    end else if (status_clr) begin
      tx_drop_d = 1'b0;
    end
  end

  // Read data is only driven during the response cycle of a read.
  always_comb begin
    avm_readdata = '0;
    if (rd_resp) begin
      if (addr_q == RX_ADDR) begin
        avm_readdata[7:0] = rx_head;
      end else if (addr_q == STATUS_ADDR) begin
        avm_readdata[RX_OK_BIT]            = !rx_empty;
        avm_readdata[TX_OK_BIT]            = !tx_full;
        avm_readdata[TX_DROP_BIT]          = tx_drop_q;
        avm_readdata[RX_COUNT_LSB +: CW]   = rx_count;
      end
    end
  end

  // Bus state and latched request; reset aborts any access in flight.
  always_ff @(posedge avm_clk or negedge avm_rst) begin
    if (!avm_rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rd_op_q   <= 1'b0;
      tx_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rd_op_q   <= rd_op_d;
      tx_drop_q <= tx_drop_d;
    end
  end

endmodule

// File: tb/tb_rs232_avm_slave.sv
// Self-checking bench for rs232_avm_slave: directed scenarios plus randomized
// traffic, all compared every cycle against a queue-based model of the slave.
module tb_rs232_avm_slave;

  localparam int D = 8;

  logic        avm_clk = 1'b0;
  logic        avm_rst;
  logic [4:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rx_ready;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;

  int nChecks = 0;
  int nPass   = 0;
  bit randomSerial = 0;

  // Model state: FIFO contents, sticky drop flag, and the access being answered.
  byte unsigned rxQ[$];
  byte unsigned txQ[$];
  bit           mDrop   = 0;
  bit           mInResp = 0;
  bit           mRead   = 0;
  logic [4:0]   mAddr   = '0;

  rs232_avm_slave dut (
    .avm_clk         (avm_clk),
    .avm_rst         (avm_rst),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .i_rx_data       (i_rx_data),
    .i_rx_valid      (i_rx_valid),
    .o_rx_ready      (o_rx_ready),
    .o_tx_data       (o_tx_data),
    .o_tx_valid      (o_tx_valid),
    .i_tx_ready      (i_tx_ready)
  );

  // Free-running clock.
  always #5 avm_clk = ~avm_clk;

  // Hard stop in case something never returns.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic modelReset();
    rxQ.delete();
    txQ.delete();
    mDrop   = 0;
    mInResp = 0;
    mRead   = 0;
    mAddr   = '0;
  endtask

  function automatic logic [31:0] expStatus();
    logic [31:0] s;
    s = 32'(rxQ.size()) << 8;
    if (rxQ.size() != 0) s |= 32'h80;
    if (txQ.size() < D)  s |= 32'h40;
    if (mDrop)           s |= 32'h20;
    return s;
  endfunction

  function automatic bit mRxPop();
    return mInResp && mRead && (mAddr == 5'd0) && (rxQ.size() > 0);
  endfunction

  function automatic logic [31:0] expReadData();
    if (!(mInResp && mRead)) return 32'h0;
    if (mAddr == 5'd0) return (rxQ.size() > 0) ? {24'h0, rxQ[0]} : 32'h0;
    if (mAddr == 5'd8) return expStatus();
    return 32'h0;
  endfunction

  // Compare every DUT output against the model for the current cycle.
  task automatic checkOutput();
    checkVal("waitrequest", {31'h0, avm_waitrequest}, {31'h0, !mInResp});
    checkVal("readdata", avm_readdata, expReadData());
    checkVal("tx_valid", {31'h0, o_tx_valid}, {31'h0, txQ.size() > 0});
    checkVal("tx_data", {24'h0, o_tx_data}, (txQ.size() > 0) ? {24'h0, txQ[0]} : 32'h0);
    checkVal("rx_ready", {31'h0, o_rx_ready}, {31'h0, (rxQ.size() < D) || mRxPop()});
  endtask

  // Randomize the serial-side inputs for one cycle.
  task automatic applyStimulus();
    i_rx_valid = ($urandom_range(0, 1) == 1);
    i_rx_data  = 8'($urandom);
    i_tx_ready = ($urandom_range(0, 3) != 0);
  endtask

  // One clock: check outputs, then advance the model by what the edge does.
  task automatic cycle();
    bit rxPop, rxPush, txPop, txWr, txRoom, dropClr, req, reqRead;
    byte unsigned rxByte, txByte;
    logic [4:0] reqAddr;
    checkOutput();
    rxPop   = mRxPop();
    rxPush  = i_rx_valid && ((rxQ.size() < D) || rxPop);
    txPop   = (txQ.size() > 0) && i_tx_ready;
    txWr    = mInResp && !mRead && (mAddr == 5'd4);
    txRoom  = (txQ.size() < D) || txPop;
    dropClr = mInResp && mRead && (mAddr == 5'd8);
    rxByte  = i_rx_data;
    txByte  = avm_writedata[7:0];
    req     = avm_read || avm_write;
    reqRead = avm_read;
    reqAddr = avm_address;
    @(posedge avm_clk);
    if (!avm_rst) begin
      modelReset();
    end else begin
      if (rxPop) void'(rxQ.pop_front());
      if (rxPush) rxQ.push_back(rxByte);
      if (txPop) void'(txQ.pop_front());
      if (txWr && txRoom) txQ.push_back(txByte);
      if (txWr && !txRoom) mDrop = 1;
      else if (dropClr) mDrop = 0;
      if (mInResp) mInResp = 0;
      else if (req) begin
        mInResp = 1;
        mRead   = reqRead;
        mAddr   = reqAddr;
      end
    end
    @(negedge avm_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      if (randomSerial) applyStimulus();
      cycle();
    end
  endtask

  // Master side: hold the request until waitrequest drops, bounded.
  task automatic busAccess(input bit isRead, input bit isWrite, input logic [4:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata, output int latency);
    bit done;
    done          = 0;
    rdata         = '0;
    latency       = 0;
    avm_read      = isRead;
    avm_write     = isWrite;
    avm_address   = addr;
    avm_writedata = wdata;
    for (int i = 0; i < 8 && !done; i++) begin
      if (randomSerial) applyStimulus();
      latency++;
      if (avm_waitrequest === 1'b0) begin
        done  = 1;
        rdata = avm_readdata;
      end
      cycle();
    end
    checkVal("accepted", {31'h0, done}, 32'h1);
    avm_read  = 0;
    avm_write = 0;
  endtask

  initial begin
    logic [31:0]  rd;
    int           lat;
    byte unsigned fillBytes[D];
    logic [4:0]   addrList[6];

    addrList      = '{5'd0, 5'd4, 5'd8, 5'd12, 5'd3, 5'd31};
    avm_rst       = 1'b0;
    avm_address   = '0;
    avm_read      = 0;
    avm_write     = 0;
    avm_writedata = '0;
    i_rx_data     = '0;
    i_rx_valid    = 0;
    i_tx_ready    = 0;

    // Reset values.
    @(negedge avm_clk);
    checkVal("rst_waitrequest", {31'h0, avm_waitrequest}, 32'h1);
    checkVal("rst_readdata", avm_readdata, 32'h0);
    checkVal("rst_tx_valid", {31'h0, o_tx_valid}, 32'h0);
    checkVal("rst_tx_data", {24'h0, o_tx_data}, 32'h0);
    checkVal("rst_rx_ready", {31'h0, o_rx_ready}, 32'h1);
    idle(2);
    avm_rst = 1'b1;
    idle(2);

    // Two received bytes, status, drain, status.
    i_rx_valid = 1; i_rx_data = 8'h41; cycle();
    i_rx_data = 8'h42; cycle();
    i_rx_valid = 0;
    busAccess(1, 0, 5'd8, 0, rd, lat);
    checkVal("status_two_rx", rd, 32'h0000_02C0);
    busAccess(1, 0, 5'd0, 0, rd, lat);
    checkVal("rx_first", rd, 32'h41);
    busAccess(1, 0, 5'd0, 0, rd, lat);
    checkVal("rx_second", rd, 32'h42);
    busAccess(1, 0, 5'd8, 0, rd, lat);
    checkVal("status_drained", rd, 32'h0000_0040);

    // Empty RX read: zero data, accepted one cycle after the request.
    busAccess(1, 0, 5'd0, 0, rd, lat);
    checkVal("rx_empty_data", rd, 32'h0);
    checkVal("rx_empty_latency", 32'(lat), 32'd2);
    checkVal("wait_back_high", {31'h0, avm_waitrequest}, 32'h1);

    // TX overflow: nine writes, the ninth dropped and flagged.
    i_tx_ready = 0;
    for (int i = 0; i < 9; i++) busAccess(0, 1, 5'd4, 32'(8'h10 + i), rd, lat);
    busAccess(1, 0, 5'd8, 0, rd, lat);
    checkVal("status_tx_drop", rd, 32'h0000_0020);
    busAccess(1, 0, 5'd8, 0, rd, lat);
    checkVal("status_drop_cleared", rd, 32'h0000_0000);

    // TX drain: one byte per cycle in order, then empty.
    i_tx_ready = 1;
    for (int i = 0; i < 8; i++) begin
      checkVal("tx_stream", {23'h0, o_tx_valid, o_tx_data}, {23'h0, 1'b1, 8'(8'h10 + i)});
      cycle();
    end
    checkVal("tx_drained", {31'h0, o_tx_valid}, 32'h0);
    i_tx_ready = 0;

    // RX full with a pending serial byte: bus pop and serial push in one cycle.
    i_rx_valid = 1;
    for (int i = 0; i < D; i++) begin
      fillBytes[i] = 8'($urandom);
      i_rx_data    = fillBytes[i];
      cycle();
    end
    i_rx_data = 8'h55;
    checkVal("rx_full_not_ready", {31'h0, o_rx_ready}, 32'h0);
    busAccess(1, 0, 5'd0, 0, rd, lat);
    checkVal("rx_full_pop", rd, {24'h0, fillBytes[0]});
    busAccess(1, 0, 5'd8, 0, rd, lat);
    checkVal("status_full_count", rd, 32'h0000_08C0);
    i_rx_valid = 0;
    for (int i = 1; i < D; i++) begin
      busAccess(1, 0, 5'd0, 0, rd, lat);
      checkVal("rx_full_drain", rd, {24'h0, fillBytes[i]});
    end
    busAccess(1, 0, 5'd0, 0, rd, lat);
    checkVal("rx_last_55", rd, 32'h55);

    // Randomized traffic on both sides, including read+write together.
    randomSerial = 1;
    for (int i = 0; i < 150; i++) begin
      bit r, w;
      r = ($urandom_range(0, 1) == 1);
      w = !r || ($urandom_range(0, 7) == 0);
      busAccess(r, w, addrList[$urandom_range(0, 5)], $urandom, rd, lat);
      idle($urandom_range(0, 2));
    end
    randomSerial = 0;
    i_rx_valid = 0;
    i_tx_ready = 1;
    idle(12);

    // Reset during the response cycle of a TX write.
    i_tx_ready = 0;
    busAccess(0, 1, 5'd4, 32'h66, rd, lat);
    avm_write = 1; avm_address = 5'd4; avm_writedata = 32'h77;
    cycle();
    checkVal("pre_rst_wait", {31'h0, avm_waitrequest}, 32'h0);
    checkVal("pre_rst_tx_valid", {31'h0, o_tx_valid}, 32'h1);
    avm_rst = 1'b0;
    #1;
    modelReset();
    checkVal("mid_rst_wait", {31'h0, avm_waitrequest}, 32'h1);
    checkVal("mid_rst_tx_valid", {31'h0, o_tx_valid}, 32'h0);
    checkVal("mid_rst_readdata", avm_readdata, 32'h0);
    avm_write = 0;
    cycle();
    avm_rst = 1'b1;
    idle(3);
    checkVal("post_rst_tx_empty", {31'h0, o_tx_valid}, 32'h0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/rs232_avm_slave.md
RS232_AVM_SLAVE -- requirements
Module: rs232_avm_slave

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, RX and TX byte FIFO depth (power of two, 2..8).
REQ-002 SHALL have parameter RX_BASE, default 0, RX data register byte address.
REQ-003 SHALL have parameter TX_BASE, default 4, TX data register byte address.
REQ-004 SHALL have parameter STATUS_BASE, default 8, status register byte address.
REQ-005 SHALL have port avm_clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port avm_rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port avm_address  input  5  Avalon-MM byte address.
REQ-008 SHALL have port avm_read  input  1  read request, held by the master until waitrequest low.
REQ-009 SHALL have port avm_readdata  output  32  read response data.
REQ-010 SHALL have port avm_write  input  1  write request, held by the master until waitrequest low.
REQ-011 SHALL have port avm_writedata  input  32  write data; only [7:0] used.
REQ-012 SHALL have port avm_waitrequest  output  1  high = access not yet accepted.
REQ-013 SHALL have port i_rx_data  input  8  incoming byte from serial side.
REQ-014 SHALL have port i_rx_valid  input  1  i_rx_data valid.
REQ-015 SHALL have port o_rx_ready  output  1  RX FIFO not full.
REQ-016 SHALL have port o_tx_data  output  8  head byte of TX FIFO.
REQ-017 SHALL have port o_tx_valid  output  1  TX FIFO not empty.
REQ-018 SHALL have port i_tx_ready  input  1  serial side consumes o_tx_data this cycle.

Function
REQ-019 SHALL implement bus FSM S_IDLE -> S_RESP -> S_IDLE; S_IDLE samples avm_read/avm_write, enters S_RESP next cycle, S_RESP always returns to S_IDLE.
REQ-020 SHALL drive avm_waitrequest = 0 only in S_RESP, 1 otherwise: access accepted exactly one cycle after first sampled, then one idle cycle before the next.
REQ-021 SHALL latch address and operation on S_IDLE -> S_RESP; avm_read has priority when both read and write are asserted.
REQ-022 SHALL drive avm_readdata only in S_RESP of a read; 0 in every other cycle.
REQ-023 SHALL, on RX_BASE read: readdata[7:0] = RX head byte, [31:8] = 0, pop RX at end of S_RESP; RX empty -> readdata 0, no pop.
REQ-024 SHALL, on STATUS_BASE read: bit7 RX_OK = RX non-empty, bit6 TX_OK = TX not full, bit5 TX_DROP sticky flag, bits[11:8] RX count, other bits 0; TX_DROP cleared at end of that S_RESP.
REQ-025 SHALL, on TX_BASE write: push avm_writedata[7:0] at end of S_RESP; TX full -> byte dropped, TX_DROP set.
REQ-026 SHALL treat reads of TX_BASE or unmapped addresses as readdata 0 with no side effect; writes to RX_BASE, STATUS_BASE or unmapped addresses are ignored but still complete via S_RESP.
REQ-027 SHALL push i_rx_data when i_rx_valid && o_rx_ready; pop TX when o_tx_valid && i_tx_ready.
REQ-028 SHALL allow simultaneous push and pop on one FIFO in one cycle, count unchanged, including when full (bus pop frees the slot) or empty (no pop, push only).
REQ-029 SHALL wrap FIFO pointers modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
REQ-030 SHALL present status sampled in S_RESP cycle (post-previous-edge state), not predicted.

Reset
REQ-031 SHALL on avm_rst low, asynchronously: FSM S_IDLE, avm_waitrequest 1, avm_readdata 0, both FIFOs empty, TX_DROP 0, o_tx_valid 0, o_tx_data 0, o_rx_ready 1.
REQ-032 SHALL abort any access in progress on reset without side effect; master re-issues.

Structure
REQ-033 SHALL place the register offsets, status bit positions (RX_OK_BIT 7, TX_OK_BIT 6, TX_DROP_BIT 5) and bus FSM enum in a shared package used also by the bus master wrapper.
REQ-034 SHALL instantiate sub-module uart_byte_fifo twice (RX, TX) with push/pop/full/empty/count/head ports.

Verification
REQ-035 SHALL cover: i_rx_valid with 0x41,0x42; poll STATUS -> bit7=1, count 2; read RX twice -> 0x41 then 0x42; STATUS -> 0x00000040.
REQ-036 SHALL cover: i_tx_ready=0, 9 writes to TX_BASE (0x10..0x18) -> first 8 queued, STATUS bit5=1, bit6=0; next STATUS read -> bit5=0.
REQ-037 SHALL cover: then i_tx_ready=1 -> o_tx_data 0x10..0x17 on 8 consecutive cycles, then o_tx_valid 0.
REQ-038 SHALL cover: read RX_BASE when empty -> readdata 0, waitrequest low exactly one cycle, one cycle after request.
REQ-039 SHALL cover: RX full, i_rx_valid held with 0x55 while bus pops -> push and pop same cycle, count stays 8, 0x55 read last.
REQ-040 SHALL cover: avm_rst low during S_RESP of a TX write -> waitrequest 1 immediately, TX empty, o_tx_valid 0.
